kplic_ahb2regbus: RTL
=====================

// Module: kplic_ahb2regbus
// PURPOSE
//  AHB-Lite slave front end for the KPLIC register bank. Accepts AHB transfers and issues
//  single-cycle regbus accesses (valid_reg_access/addr/rd_wr/write_data) to the register block.
//  Returns the register block's combinational read_data on the AHB bus.
//  Guarantees exactly one valid_reg_access pulse per accepted transfer, so a read of the MPPI
//  register produces exactly one int_claim.
// PARAMETERS
//  ADDR_LIMIT  12'h040  first regbus offset outside the register map; at or above -> ERROR
// PORTS
//  kplic_clk         in   1   KPLIC clock
//  kplic_rstn        in   1   KPLIC reset; asynchronous, active low
//  hsel              in   1   AHB slave select
//  haddr             in   32  AHB address; only [11:0] used, upper bits decoded externally
//  htrans            in   2   AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
//  hwrite            in   1   AHB direction; 1 = write
//  hsize             in   3   AHB size; only 3'b010 (word) is legal
//  hwdata            in   32  AHB write data, valid in the data phase
//  hready_in         in   1   AHB bus ready (previous transfer done)
//  hready_out        out  1   slave ready
//  hresp             out  1   0 = OKAY, 1 = ERROR
//  hrdata            out  32  AHB read data
//  valid_reg_access  out  1   regbus access strobe, one cycle per access
//  addr              out  12  regbus offset
//  rd_wr             out  1   regbus command; 1 = write, 0 = read
//  write_data        out  32  regbus write data
//  read_data         in   32  regbus read data, combinational, same cycle as the read strobe
// BEHAVIOUR
//  Reset values: hready_out=1, hresp=0, hrdata=0, valid_reg_access=0, addr=0, rd_wr=0,
//    write_data=0, state=IDLE.
//  Address phase accepted when hsel & hready_in & htrans[1] = 1.
//    On acceptance: latch haddr[11:0], hwrite and the error check.
//    error = (hsize != 3'b010) | (haddr[1:0] != 0) | (haddr[11:0] >= ADDR_LIMIT).
//  FSM, with the next state taken at acceptance:
//    error             -> ERR1
//    write, no error   -> WR
//    read, no error    -> RD1
//    no acceptance     -> IDLE
//  Per-state outputs and transitions:
//    IDLE: hready_out=1, hresp=0; no regbus strobe.
//    WR: valid_reg_access=1, rd_wr=1, write_data=hwdata, hready_out=1.
//      The register updates at the end of this cycle. Zero-wait write.
//    RD1: valid_reg_access=1, rd_wr=0, hready_out=0; hrdata <= read_data at the clock edge.
//      Always goes to RD2.
//    RD2: hready_out=1, hrdata stable, no strobe. One wait state per read.
//    ERR1: hready_out=0, hresp=1, no strobe. Always goes to ERR2.
//    ERR2: hready_out=1, hresp=1, no strobe.
//  Pipelining: in WR, RD2, ERR2 and IDLE a new address phase is sampled in the same cycle.
//    Back-to-back transfers therefore have no idle gap.
//    In RD1 and ERR1 no address is sampled, since hready_in is low.
//  Idle-type transfers: IDLE/BUSY transfers or hsel=0 -> OKAY, no regbus access.
//  Register hold rules:
//    addr holds the last latched offset.
//    write_data=0 outside WR.
//    hrdata changes only on the RD1 edge.
//    rd_wr=0 outside WR.
//  Read-after-write: a read immediately following a write to the same offset returns the
//    newly written value, because the write commits before RD1.
//  Errored transfers never reach the regbus: no write occurs and no claim is generated.
//  Reset mid-transfer: all outputs take reset values immediately; a pending read or error is
//    dropped with no strobe.
// TESTING
//  1. Write 0xA5A5_0003 to 0x004, hsize=010 -> one cycle valid_reg_access=1, rd_wr=1,
//     addr=0x004, write_data=0xA5A5_0003; hready_out stays 1.
//  2. Read 0x004 after test 1 -> RD1: strobe with rd_wr=0 and hready_out=0; next cycle
//     hready_out=1, hrdata=0xA5A5_0003.
//  3. NONSEQ write 0x1234 to 0x008 immediately followed by a read of 0x008 -> read completes
//     with hrdata=0x0000_1234; exactly 2 strobes in total.
//  4. Read at haddr=0x006, or hsize=000, or haddr=ADDR_LIMIT -> hresp=1 for 2 cycles
//     (hready_out 0 then 1); valid_reg_access never asserted.
//  5. hsel=1 with htrans=IDLE, then with htrans=BUSY, for 4 cycles -> hready_out=1, hresp=0,
//     no strobe.
//  6. Assert kplic_rstn=0 during RD1 of an MPPI read -> all outputs at reset values that
//     cycle, no further strobe; a subsequent MPPI read gives exactly one strobe/claim.

Source files
------------

// File: rtl/kplic_ahb2regbus.sv
// AHB-Lite slave front end for the KPLIC register bank: converts accepted AHB
// transfers into single-cycle regbus strobes and returns read data on hrdata.
module kplic_ahb2regbus #(
  parameter logic [11:0] ADDR_LIMIT = 12'h040
) (
  input  logic        kplic_clk,
  input  logic        kplic_rstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        valid_reg_access,
  output logic [11:0] addr,
  output logic        rd_wr,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    ERR1 = 3'd4,
    ERR2 = 3'd5
  } state_t;

  state_t state;
  logic   accept;
  logic   xfer_err;
  logic   unused_inputs;

  function automatic logic check_err(input logic [2:0] size, input logic [11:0] offset);
    return (size != 3'b010) || (offset[1:0] != 2'b00) || (offset >= ADDR_LIMIT);
  endfunction

  assign unused_inputs = ^{haddr[31:12], htrans[0]};

  // Address-phase acceptance; RD1/ERR1 never sample even if hready_in is mis-driven.
  always_comb begin
    accept   = hsel & hready_in & htrans[1] & (state != RD1) & (state != ERR1);
    xfer_err = check_err(hsize, haddr[11:0]);
  end

  // hwdata is only valid in the data phase, so write_data follows it combinationally in WR.
  always_comb begin
    if (state == WR) begin
      write_data = hwdata;
    end else begin
      write_data = 32'h0000_0000;
    end
  end

  // Transfer FSM with registered bus and regbus outputs.
  always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
    if (!kplic_rstn) begin
      state            <= IDLE;
      hready_out       <= 1'b1;
      hresp            <= 1'b0;
      hrdata           <= 32'h0000_0000;
      valid_reg_access <= 1'b0;
      addr             <= 12'h000;
      rd_wr            <= 1'b0;
    end else begin
      case (state)
        RD1: begin
          state            <= RD2;
          hrdata           <= read_data;
          valid_reg_access <= 1'b0;
          rd_wr            <= 1'b0;
          hready_out       <= 1'b1;
          hresp            <= 1'b0;
        end
        ERR1: begin
          state            <= ERR2;
          valid_reg_access <= 1'b0;
          rd_wr            <= 1'b0;
          hready_out       <= 1'b1;
          hresp            <= 1'b1;
        end
        default: begin
          if (accept) begin
            addr <= haddr[11:0];
            if (xfer_err) begin
              state            <= ERR1;
              valid_reg_access <= 1'b0;
              rd_wr            <= 1'b0;
              hready_out       <= 1'b0;
              hresp            <= 1'b1;
            end else if (hwrite) begin
              state            <= WR;
              valid_reg_access <= 1'b1;
              rd_wr            <= 1'b1;
              hready_out       <= 1'b1;
              hresp            <= 1'b0;
            end else begin
              state            <= RD1;
              valid_reg_access <= 1'b1;
              rd_wr            <= 1'b0;
              hready_out       <= 1'b0;
              hresp            <= 1'b0;
            end
          end else begin
            state            <= IDLE;
            valid_reg_access <= 1'b0;
            rd_wr            <= 1'b0;
            hready_out       <= 1'b1;
            hresp            <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
